// File: rtl/mem_ctrl.sv
// Byte-sequencing controller that shares a byte-wide synchronous RAM between the
// IF (word reads) and MEM (1/2/4-byte reads/writes) requesters. Optional macro
// MEM_CTRL_RR_EN switches contention from fixed MEM priority to round-robin.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic [31:0]           if_data_out,
  output logic                  if_done_out,
  input  logic                  mem_req_in,
  input  logic                  mem_wr_in,
  input  logic [1:0]            mem_size_in,
  input  logic [31:0]           mem_addr_in,
  input  logic [31:0]           mem_wdata_in,
  output logic [31:0]           mem_rdata_out,
  output logic                  mem_done_out,
  output logic                  busy_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  if_done_q, if_done_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  mem_done_q, mem_done_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_r_nw_q, ram_r_nw_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_d_q, ram_d_d;
`ifdef MEM_CTRL_RR_EN
  owner_e                last_q, last_d;
`endif

  logic       grant_any;
  logic       grant_mem;
  logic [2:0] nxt_idx;

  // Only the low ADDR_WIDTH address bits reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr_in[31:ADDR_WIDTH], mem_addr_in[31:ADDR_WIDTH]};

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always_comb begin
    grant_any = mem_req_in | if_req_in;
`ifdef MEM_CTRL_RR_EN
    if (mem_req_in && if_req_in) begin
      grant_mem = (last_q == OWN_IF);
    end else begin
      grant_mem = mem_req_in;
    end
`else
    grant_mem = mem_req_in;
`endif
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    base_d      = base_q;
    n_d         = n_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_done_d   = 1'b0;
    if_data_d   = '0;
    mem_done_d  = 1'b0;
    mem_rdata_d = '0;
    ram_en_d    = 1'b0;
    ram_r_nw_d  = 1'b1;
    ram_a_d     = ram_a_q;
    ram_d_d     = '0;
    nxt_idx     = idx_q + 3'd1;
`ifdef MEM_CTRL_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          idx_d    = '0;
          buf_d    = '0;
          ram_en_d = 1'b1;
          if (grant_mem) begin
            owner_d    = OWN_MEM;
            base_d     = mem_addr_in[ADDR_WIDTH-1:0];
            n_d        = size_to_n(mem_size_in);
            wdata_d    = mem_wdata_in;
            ram_a_d    = mem_addr_in[ADDR_WIDTH-1:0];
            ram_r_nw_d = ~mem_wr_in;
            ram_d_d    = mem_wr_in ? mem_wdata_in[7:0] : 8'h00;
            state_d    = mem_wr_in ? S_WRITE : S_READ;
          end else begin
            owner_d = OWN_IF;
            base_d  = if_addr_in[ADDR_WIDTH-1:0];
            n_d     = 3'd4;
            ram_a_d = if_addr_in[ADDR_WIDTH-1:0];
            state_d = S_READ;
          end
`ifdef MEM_CTRL_RR_EN
          last_d = grant_mem ? OWN_MEM : OWN_IF;
`endif
        end
      end

      S_READ: begin
        // RAM data lags the address by one cycle, so index k returns byte k-1.
        if (idx_q != 3'd0) begin
          buf_d = buf_q | (32'(ram_d_in) << {idx_q - 3'd1, 3'b000});
        end
        if (idx_q == n_q) begin
          state_d = S_DONE;
          if (owner_q == OWN_MEM) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = buf_d & byte_mask(n_q);
          end else begin
            if_done_d = 1'b1;
            if_data_d = buf_d & byte_mask(n_q);
          end
        end else begin
          idx_d = nxt_idx;
          if (nxt_idx < n_q) begin
            ram_en_d = 1'b1;
            ram_a_d  = base_q + ADDR_WIDTH'(nxt_idx);
          end
        end
      end

      S_WRITE: begin
        if (nxt_idx < n_q) begin
          idx_d      = nxt_idx;
          ram_en_d   = 1'b1;
          ram_r_nw_d = 1'b0;
          ram_a_d    = base_q + ADDR_WIDTH'(nxt_idx);
          ram_d_d    = 8'(wdata_q >> {nxt_idx, 3'b000});
        end else begin
          state_d    = S_DONE;
          mem_done_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments only, so every register samples the pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the assembly buffer is reset as well, so a dropped read cannot leak bytes.
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      base_q      <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_data_q   <= '0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_r_nw_q  <= 1'b0;
      ram_a_q     <= '0;
      ram_d_q     <= '0;
`ifdef MEM_CTRL_RR_EN
      last_q      <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      ram_en_q    <= ram_en_d;
      ram_r_nw_q  <= ram_r_nw_d;
      ram_a_q     <= ram_a_d;
      ram_d_q     <= ram_d_d;
`ifdef MEM_CTRL_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign busy_out      = (state_q != S_IDLE);
  assign if_data_out   = if_data_q;
  assign if_done_out   = if_done_q;
  assign mem_rdata_out = mem_rdata_q;
  assign mem_done_out  = mem_done_q;
  assign ram_en_out    = ram_en_q;
  assign ram_r_nw_out  = ram_r_nw_q;
  assign ram_a_out     = ram_a_q;
  assign ram_d_out     = ram_d_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array reference model predicts each
// transaction in service order; a monitor checks RAM traffic, data and latency.
module tb_mem_ctrl;

  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic          clk_in;
  logic          rst_in;
  logic          if_req_in;
  logic [31:0]   if_addr_in;
  logic [31:0]   if_data_out;
  logic          if_done_out;
  logic          mem_req_in;
  logic          mem_wr_in;
  logic [1:0]    mem_size_in;
  logic [31:0]   mem_addr_in;
  logic [31:0]   mem_wdata_in;
  logic [31:0]   mem_rdata_out;
  logic          mem_done_out;
  logic          busy_out;
  logic          ram_en_out;
  logic          ram_r_nw_out;
  logic [AW-1:0] ram_a_out;
  logic [7:0]    ram_d_out;
  logic [7:0]    ram_d_in;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_data_out  (if_data_out),
    .if_done_out  (if_done_out),
    .mem_req_in   (mem_req_in),
    .mem_wr_in    (mem_wr_in),
    .mem_size_in  (mem_size_in),
    .mem_addr_in  (mem_addr_in),
    .mem_wdata_in (mem_wdata_in),
    .mem_rdata_out(mem_rdata_out),
    .mem_done_out (mem_done_out),
    .busy_out     (busy_out),
    .ram_en_out   (ram_en_out),
    .ram_r_nw_out (ram_r_nw_out),
    .ram_a_out    (ram_a_out),
    .ram_d_out    (ram_d_out),
    .ram_d_in     (ram_d_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Synchronous byte RAM with one-cycle read latency.
  logic [7:0] ram_arr [0:DEPTH-1];
  always @(posedge clk_in) begin
    if (ram_en_out) begin
      if (ram_r_nw_out) ram_d_in <= ram_arr[ram_a_out];
      else              ram_arr[ram_a_out] <= ram_d_out;
    end
  end

  typedef struct {
    bit            is_mem;
    bit            wr;
    logic [AW-1:0] base;
    int            n;
    logic [31:0]   wdata;
    logic [31:0]   data;
    int            lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [0:DEPTH-1];
  bit         last_mem = 1'b0;
  int         checks   = 0;
  int         errors   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_byte(input logic [AW-1:0] a, input logic [7:0] v);
    ram_arr[a] <= v;
    ref_mem[a] = v;
  endtask

  // Reference model: byte-array semantics, little-endian, wrapping addresses.
  task automatic push_txn(input bit is_mem, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic [AW-1:0] a;
    e.is_mem = is_mem;
    e.wr     = is_mem && wr;
    e.base   = addr[AW-1:0];
    e.n      = !is_mem ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.wdata  = wdata;
    e.data   = '0;
    for (int i = 0; i < e.n; i++) begin
      a = AW'(e.base + AW'(i));
      if (e.wr) ref_mem[a] = wdata[8*i +: 8];
      else      e.data[8*i +: 8] = ref_mem[a];
    end
    // Cycles from the first busy cycle to the done cycle.
    e.lat    = e.wr ? e.n : e.n + 1;
    last_mem = is_mem;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    int   k;
    int   start;
    bit   busy_prev;
    exp_t e;
    k = 0;
    start = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        k = 0;
      end else begin
        if (busy_out && !busy_prev) start = cyc;
        if (ram_en_out) begin
          if (exp_q.size() == 0 || k >= exp_q[0].n) begin
            checks++;
            errors++;
            $display("FAIL ram_extra: unexpected access addr %h (cycle %0d)", ram_a_out, cyc);
          end else begin
            e = exp_q[0];
            check("ram_a", 32'(ram_a_out), 32'(AW'(e.base + AW'(k))));
            check("ram_r_nw", 32'(ram_r_nw_out), 32'(!e.wr));
            if (e.wr) check("ram_d", 32'(ram_d_out), 32'(e.wdata[8*k +: 8]));
          end
          k++;
        end else begin
          check("ram_d_idle", 32'(ram_d_out), 32'h0);
        end
        if (if_done_out || mem_done_out) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: if=%b mem=%b (cycle %0d)", if_done_out, mem_done_out, cyc);
          end else begin
            e = exp_q.pop_front();
            check("done_owner", 32'({if_done_out, mem_done_out}), e.is_mem ? 32'h1 : 32'h2);
            if (e.is_mem) check("mem_rdata", mem_rdata_out, e.data);
            else          check("if_data", if_data_out, e.data);
            check("latency", 32'(cyc - start), 32'(e.lat));
            check("byte_count", 32'(k), 32'(e.n));
          end
          k = 0;
        end
        if (!if_done_out)  check("if_data_idle", if_data_out, 32'h0);
        if (!mem_done_out) check("mem_rdata_idle", mem_rdata_out, 32'h0);
      end
      busy_prev = busy_out;
    end
  end

  task automatic wait_done(input bit want_mem);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (want_mem ? mem_done_out : if_done_out) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no %s done within 60 cycles", want_mem ? "mem" : "if");
  endtask

  task automatic drive_mem(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    mem_wr_in    = wr;
    mem_size_in  = size;
    mem_addr_in  = addr;
    mem_wdata_in = wdata;
  endtask

  task automatic single(input bit is_mem, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    push_txn(is_mem, wr, size, addr, wdata);
    @(posedge clk_in); #1;
    if (is_mem) begin
      drive_mem(wr, size, addr, wdata);
      mem_req_in = 1'b1;
    end else begin
      if_addr_in = addr;
      if_req_in  = 1'b1;
    end
    // Inputs other than the held request are ignored once granted.
    @(posedge clk_in); #1;
    if_addr_in = $urandom;
    drive_mem(1'($urandom), 2'($urandom), $urandom, $urandom);
    wait_done(is_mem);
    @(posedge clk_in); #1;
    mem_req_in = 1'b0;
    if_req_in  = 1'b0;
  endtask

  task automatic contend(input logic [31:0] if_addr, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bit mem_first;
`ifdef MEM_CTRL_RR_EN
    mem_first = !last_mem;
`else
    mem_first = 1'b1;
`endif
    if (mem_first) begin
      push_txn(1'b1, wr, size, addr, wdata);
      push_txn(1'b0, 1'b0, 2'b10, if_addr, 32'h0);
    end else begin
      push_txn(1'b0, 1'b0, 2'b10, if_addr, 32'h0);
      push_txn(1'b1, wr, size, addr, wdata);
    end
    @(posedge clk_in); #1;
    drive_mem(wr, size, addr, wdata);
    if_addr_in = if_addr;
    mem_req_in = 1'b1;
    if_req_in  = 1'b1;
    wait_done(mem_first);
    @(posedge clk_in); #1;
    if (mem_first) mem_req_in = 1'b0;
    else           if_req_in  = 1'b0;
    wait_done(!mem_first);
    @(posedge clk_in); #1;
    mem_req_in = 1'b0;
    if_req_in  = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi;
    logic [31:0] lo;
    hi = $urandom;
    hi[AW-1:0] = '0;
    if ($urandom_range(0, 3) == 0) lo = 32'(DEPTH - 4) + 32'($urandom_range(0, 3));
    else                           lo = 32'($urandom_range(0, 63));
    return hi | lo;
  endfunction

  initial begin : driver
    rst_in       = 1'b1;
    if_req_in    = 1'b0;
    if_addr_in   = '0;
    mem_req_in   = 1'b0;
    drive_mem(1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) set_byte(AW'(i), 8'($urandom));
    set_byte(17'h00010, 8'h13);
    set_byte(17'h00011, 8'h00);
    set_byte(17'h00012, 8'h05);
    set_byte(17'h00013, 8'h93);
    set_byte(17'h1FFFF, 8'h34);
    set_byte(17'h00000, 8'h12);

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_ram_en", 32'(ram_en_out), 32'h0);
    check("rst_ram_r_nw", 32'(ram_r_nw_out), 32'h0);
    check("rst_ram_a", 32'(ram_a_out), 32'h0);
    check("rst_if_done", 32'(if_done_out), 32'h0);
    check("rst_mem_done", 32'(mem_done_out), 32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    single(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0);
    single(1'b1, 1'b1, 2'b00, 32'h0000_0104, 32'hAABB_CCDD);
    single(1'b1, 1'b0, 2'b00, 32'h0000_0104, 32'h0);
    single(1'b1, 1'b0, 2'b01, 32'h0001_FFFF, 32'h0);
    single(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFE, 32'h1122_3344);
    single(1'b1, 1'b0, 2'b10, 32'h0001_FFFE, 32'h0);
    contend(32'h0000_0010, 1'b1, 2'b10, 32'h0000_0200, 32'hDEAD_BEEF);
    repeat (2) contend(32'h0000_0200, 1'b0, 2'b01, 32'h0000_0010, 32'h0);

    // Reset three cycles into an IF word read; the held request restarts from byte 0.
    push_txn(1'b0, 1'b0, 2'b10, 32'h0000_0020, 32'h0);
    @(posedge clk_in); #1;
    if_addr_in = 32'h0000_0020;
    if_req_in  = 1'b1;
    repeat (3) begin @(posedge clk_in); #1; end
    rst_in = 1'b1;
    exp_q.delete();
    last_mem = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check("rst_mid_busy", 32'(busy_out), 32'h0);
    check("rst_mid_ram_en", 32'(ram_en_out), 32'h0);
    check("rst_mid_ram_a", 32'(ram_a_out), 32'h0);
    check("rst_mid_if_done", 32'(if_done_out), 32'h0);
    check("rst_mid_if_data", if_data_out, 32'h0);
    @(posedge clk_in); #1;
    push_txn(1'b0, 1'b0, 2'b10, 32'h0000_0020, 32'h0);
    rst_in = 1'b0;
    wait_done(1'b0);
    @(posedge clk_in); #1;
    if_req_in = 1'b0;

    // Back-to-back: request held one cycle past done repeats the transaction.
    push_txn(1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0);
    push_txn(1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0);
    @(posedge clk_in); #1;
    drive_mem(1'b0, 2'b10, 32'h0000_0104, 32'h0);
    mem_req_in = 1'b1;
    wait_done(1'b1);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("b2b_idle_busy", 32'(busy_out), 32'h0);
    @(posedge clk_in); #1;
    mem_req_in = 1'b0;
    @(negedge clk_in);
    check("b2b_restart_busy", 32'(busy_out), 32'h1);
    wait_done(1'b1);
    @(posedge clk_in); #1;

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        contend(rand_addr(), 1'($urandom), 2'($urandom), rand_addr(), $urandom);
      end else begin
        single(1'($urandom), 1'($urandom), 2'($urandom), rand_addr(), $urandom);
      end
    end

    repeat (4) @(posedge clk_in);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
